// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg : shared types, defaults and helpers for the spiking readout stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_SCAN      = 2'd2,
        ST_DONE      = 2'd3
    } classifier_state_t;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_COUNT_W     = 8;
    localparam int DEF_WINDOW_W    = 8;

    // Holds at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                             input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : per-class spike counter with clear and saturating increment
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter
    import snn_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [COUNT_W-1:0] count_o
);

    localparam logic [COUNT_W-1:0] C_MAX = '1;

    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_count <= '0;
        end else if (inc_i) begin
            r_count <= COUNT_W'(sat_inc(32'(r_count), 32'(C_MAX)));
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/snn_window_classifier.sv
// ----------------------------------------------------------------------------
// snn_window_classifier : windowed spike counting + serial argmax readout
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snn_window_classifier
    import snn_pkg::*;
#(
    parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter  int COUNT_W     = DEF_COUNT_W,
    parameter  int WINDOW_W    = DEF_WINDOW_W,
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [WINDOW_W-1:0]    window_len_i,
    input  logic [NUM_CLASSES-1:0] spike_i,
    output logic                   busy_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [IDX_W-1:0]       class_o,
    output logic [COUNT_W-1:0]     max_count_o,
    output logic                   tie_o,
    input  logic [IDX_W-1:0]       dbg_sel_i,
    output logic [COUNT_W-1:0]     dbg_count_o
);

    classifier_state_t r_state, w_state_nxt;

    logic [WINDOW_W-1:0] r_len, r_win;
    logic [IDX_W-1:0]    r_idx, r_best_idx, r_class;
    logic [COUNT_W-1:0]  r_best, r_max;
    logic                r_tie, r_tie_out;

    logic [COUNT_W-1:0]  w_counts [NUM_CLASSES];
    logic [COUNT_W-1:0]  w_cur, w_nxt_best, w_dbg;
    logic [IDX_W-1:0]    w_nxt_idx;
    logic                w_nxt_tie;
    logic                w_start_acc, w_win_last, w_scan_last;
    classifier_state_t   w_start_state;

    assign w_win_last    = (r_win == r_len - WINDOW_W'(1));
    assign w_scan_last   = (r_idx == IDX_W'(NUM_CLASSES - 1));
    assign w_start_state = (window_len_i == '0) ? ST_SCAN : ST_INTEGRATE;

    generate
        for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_counter
            sat_counter #(
                .COUNT_W (COUNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clr_i   (w_start_acc),
                .inc_i   ((r_state == ST_INTEGRATE) && spike_i[g]),
                .count_o (w_counts[g])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = w_start_state;
                end
            end
            ST_INTEGRATE: begin
                if (w_win_last) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_scan_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // result_valid_o is implied by this state, so ready alone completes the handshake
                if (result_ready_i) begin
                    if (start_i) begin
                        w_start_acc = 1'b1;
                        w_state_nxt = w_start_state;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strict '>' keeps the earliest index on equal counts.
    always_comb begin
        w_cur      = w_counts[r_idx];
        w_nxt_best = r_best;
        w_nxt_idx  = r_best_idx;
        w_nxt_tie  = r_tie;
        if (r_idx == '0) begin
            w_nxt_best = w_cur;
            w_nxt_idx  = '0;
            w_nxt_tie  = 1'b0;
        end else if (w_cur > r_best) begin
            w_nxt_best = w_cur;
            w_nxt_idx  = r_idx;
            w_nxt_tie  = 1'b0;
        end else if (w_cur == r_best) begin
            w_nxt_tie  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len      <= '0;
            r_win      <= '0;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_tie      <= 1'b0;
            r_class    <= '0;
            r_max      <= '0;
            r_tie_out  <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_len <= window_len_i;
                r_win <= '0;
                r_idx <= '0;
            end
            if (r_state == ST_INTEGRATE) begin
                r_win <= r_win + WINDOW_W'(1);
            end
            if (r_state == ST_SCAN) begin
                r_idx      <= r_idx + IDX_W'(1);
                r_best     <= w_nxt_best;
                r_best_idx <= w_nxt_idx;
                r_tie      <= w_nxt_tie;
                if (w_scan_last) begin
                    r_class   <= w_nxt_idx;
                    r_max     <= w_nxt_best;
                    r_tie_out <= w_nxt_tie;
                end
            end
        end
    end

    always_comb begin
        w_dbg = '0;
        if ({1'b0, dbg_sel_i} < (IDX_W + 1)'(NUM_CLASSES)) begin
            w_dbg = w_counts[dbg_sel_i];
        end
    end

    assign busy_o         = (r_state == ST_INTEGRATE) || (r_state == ST_SCAN);
    assign result_valid_o = (r_state == ST_DONE);
    assign class_o        = r_class;
    assign max_count_o    = r_max;
    assign tie_o          = r_tie_out;
    assign dbg_count_o    = w_dbg;

endmodule

`default_nettype wire

// File: tb/tb_snn_window_classifier.sv
// ----------------------------------------------------------------------------
// tb_snn_window_classifier : directed scoreboard bench, default and 4-bit counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_snn_window_classifier;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] window_len_i = '0;
    logic [9:0] spike_i = '0;
    logic       result_ready_i = 1'b0;
    logic [3:0] dbg_sel_i = '0;

    logic       busy_o, result_valid_o, tie_o;
    logic [3:0] class_o;
    logic [7:0] max_count_o, dbg_count_o;

    logic       s_busy, s_valid, s_tie;
    logic [3:0] s_class, s_max, s_dbg;

    always #5 clk_i = ~clk_i;

    snn_window_classifier dut (
        .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i),
        .window_len_i (window_len_i), .spike_i (spike_i),
        .busy_o (busy_o), .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i), .class_o (class_o),
        .max_count_o (max_count_o), .tie_o (tie_o),
        .dbg_sel_i (dbg_sel_i), .dbg_count_o (dbg_count_o)
    );

    snn_window_classifier #(.COUNT_W(4)) dut_sat (
        .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i),
        .window_len_i (window_len_i), .spike_i (spike_i),
        .busy_o (s_busy), .result_valid_o (s_valid),
        .result_ready_i (result_ready_i), .class_o (s_class),
        .max_count_o (s_max), .tie_o (s_tie),
        .dbg_sel_i (dbg_sel_i), .dbg_count_o (s_dbg)
    );

    typedef struct {
        int cls;
        int mx;
        int tie;
        int s_cls;
        int s_mx;
        int s_tie;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   t0    = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int cls, input int mx, input int tie,
                        input int s_cls, input int s_mx, input int s_tie);
        exp_t e;
        e.cls = cls; e.mx = mx; e.tie = tie;
        e.s_cls = s_cls; e.s_mx = s_mx; e.s_tie = s_tie;
        sb.push_back(e);
    endtask

    task automatic start_window(input int len);
        window_len_i = 8'(len);
        start_i = 1'b1;
        tick();
        t0 = cyc;
        start_i = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        exp_t e;
        while (!result_valid_o && (cyc - t0) < 200) tick();
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({tag, "_sat_valid"}, 32'(s_valid), 32'd1);
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_class"}, 32'(class_o), 32'(e.cls));
            chk({tag, "_max"}, 32'(max_count_o), 32'(e.mx));
            chk({tag, "_tie"}, 32'(tie_o), 32'(e.tie));
            chk({tag, "_sat_class"}, 32'(s_class), 32'(e.s_cls));
            chk({tag, "_sat_max"}, 32'(s_max), 32'(e.s_mx));
            chk({tag, "_sat_tie"}, 32'(s_tie), 32'(e.s_tie));
        end
    endtask

    task automatic accept();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_class", 32'(class_o), 32'd0);
        chk("rst_max", 32'(max_count_o), 32'd0);
        chk("rst_tie", 32'(tie_o), 32'd0);

        // Basic window: class 3 every cycle, class 7 twice
        push(3, 5, 0, 3, 5, 0);
        start_window(5);
        chk("basic_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            spike_i = 10'b0000001000;
            if (i == 0 || i == 2) spike_i[7] = 1'b1;
            tick();
        end
        spike_i = '0;
        wait_result("basic", 15);
        dbg_sel_i = 4'd7; #1;
        chk("basic_dbg7", 32'(dbg_count_o), 32'd2);
        dbg_sel_i = 4'd3; #1;
        chk("basic_dbg3", 32'(dbg_count_o), 32'd5);
        dbg_sel_i = 4'd12; #1;
        chk("basic_dbg_oob", 32'(dbg_count_o), 32'd0);
        accept();
        chk("basic_idle_valid", 32'(result_valid_o), 32'd0);
        chk("basic_idle_busy", 32'(busy_o), 32'd0);
        chk("basic_idle_class_hold", 32'(class_o), 32'd3);

        // Tie between classes 2 and 6
        push(2, 4, 1, 2, 4, 1);
        start_window(4);
        spike_i = 10'b0001000100;
        repeat (4) tick();
        spike_i = '0;
        wait_result("tie", 14);
        accept();

        // Saturation: 4-bit instance clips at 15, 8-bit instance counts 40
        push(9, 40, 0, 9, 15, 0);
        start_window(40);
        spike_i = 10'b1000000000;
        repeat (40) tick();
        spike_i = '0;
        wait_result("sat", 50);
        accept();

        // Zero-length window: all counts zero, every class ties
        push(0, 0, 1, 0, 0, 1);
        start_window(0);
        chk("zero_busy", 32'(busy_o), 32'd1);
        wait_result("zero", 10);

        // Hold in DONE without ready; stray start must be ignored
        for (int i = 0; i < 7; i++) begin
            start_i = (i == 2 || i == 4);
            tick();
            chk("hold_valid", 32'(result_valid_o), 32'd1);
            chk("hold_class", 32'(class_o), 32'd0);
            chk("hold_max", 32'(max_count_o), 32'd0);
            chk("hold_tie", 32'(tie_o), 32'd1);
        end
        start_i = 1'b0;

        // Back-to-back: handshake and new start on the same edge
        push(5, 3, 0, 5, 3, 0);
        result_ready_i = 1'b1;
        start_window(3);
        result_ready_i = 1'b0;
        chk("b2b_busy", 32'(busy_o), 32'd1);
        chk("b2b_valid", 32'(result_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            spike_i = 10'b0000100000;
            if (i == 1) begin
                spike_i[1]   = 1'b1;
                start_i      = 1'b1;
                window_len_i = 8'd0;
            end
            tick();
            start_i = 1'b0;
        end
        spike_i = '0;
        wait_result("b2b", 13);
        dbg_sel_i = 4'd1; #1;
        chk("b2b_dbg1", 32'(dbg_count_o), 32'd1);
        dbg_sel_i = 4'd0; #1;
        chk("b2b_dbg0", 32'(dbg_count_o), 32'd0);
        accept();

        // Reset on cycle 3 of an L=8 window
        start_window(8);
        spike_i = '1;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        spike_i = '0;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_valid", 32'(result_valid_o), 32'd0);
        chk("mrst_class", 32'(class_o), 32'd0);
        chk("mrst_sat_busy", 32'(s_busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            dbg_sel_i = 4'(i); #1;
            chk("mrst_dbg", 32'(dbg_count_o), 32'd0);
            chk("mrst_sat_dbg", 32'(s_dbg), 32'd0);
        end
        repeat (20) tick();
        chk("mrst_no_result", 32'(result_valid_o), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snn_window_classifier.md
Name: snn_window_classifier

Overview:
- Parametrised readout stage for the spiking classifier: counts output-layer spikes per class over a programmable time window, then finds the winning class with a serial argmax scan.
- Presents the result with a valid/ready handshake.
- Successor to the fixed 10-class spike counter plus raw-count output: adds class-count and width parameters, a window controller, saturation, argmax with tie detection, and back-to-back inference.
- Sits directly after the output LIF layer; its spike vector feeds spike_i.

Parameters:
- NUM_CLASSES, 10, number of output neurons / classes (>=2).
- COUNT_W, 8, per-class spike counter width (saturating).
- WINDOW_W, 8, width of the window-length input.
- IDX_W, $clog2(NUM_CLASSES), class index width (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  begin a new inference window; accepted only in IDLE, or in DONE together with result_ready_i.
- window_len_i  in  WINDOW_W  window length L in cycles; sampled when start is accepted.
- spike_i  in  NUM_CLASSES  one bit per output neuron.
- busy_o  out  1  high in INTEGRATE or SCAN.
- result_valid_o  out  1  result available (DONE state).
- result_ready_i  in  1  consumer accepts result.
- class_o  out  IDX_W  winning class index.
- max_count_o  out  COUNT_W  spike count of the winning class.
- tie_o  out  1  another class equals the winning count.
- dbg_sel_i  in  IDX_W  debug counter select.
- dbg_count_o  out  COUNT_W  counter[dbg_sel_i], combinational; 0 if dbg_sel_i >= NUM_CLASSES.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; all counters, class_o, max_count_o and tie_o = 0; busy_o=0; result_valid_o=0.
  - Reset overrides everything, including mid-window and mid-scan; no partial result is ever presented.
- FSM states: IDLE, INTEGRATE, SCAN, DONE.
- IDLE:
  - On start_i: latch L = window_len_i, clear all counters and the window counter.
  - If L != 0, go to INTEGRATE.
  - If L == 0, go directly to SCAN with all counts 0.
- INTEGRATE:
  - spike_i is sampled on each of the L edges following the start edge.
  - counter[i] increments when spike_i[i]=1, saturating at 2^COUNT_W-1; no wrap.
  - After the L-th sample edge, go to SCAN.
  - start_i is ignored.
- SCAN:
  - One class per cycle, idx = 0..NUM_CLASSES-1, taking exactly NUM_CLASSES cycles.
  - idx 0: best = counter[0], best_idx = 0, tie = 0.
  - idx > 0, count > best: best = count, best_idx = idx, tie = 0.
  - idx > 0, count == best: tie = 1.
  - Net effect: the lowest index wins ties.
  - After the last index, go to DONE.
- DONE:
  - result_valid_o=1; class_o, max_count_o and tie_o are registered and held stable until the handshake.
  - Counters hold their values, readable via dbg.
  - Handshake completes on result_valid_o & result_ready_i at an edge.
  - If start_i is also high at that edge: next window begins immediately (same actions as IDLE start).
  - Otherwise: return to IDLE.
  - start_i without result_ready_i is ignored.
- Latency: result_valid_o rises L+NUM_CLASSES cycles after the start-accept edge (NUM_CLASSES cycles when L=0).
- busy_o = (state==INTEGRATE) | (state==SCAN).
- Result outputs keep their last values in IDLE and INTEGRATE.

Decomposition:
- Shared package snn_pkg holds:
  - state enum type classifier_state_t;
  - default LIF/classifier constants (NUM_CLASSES=10, COUNT_W=8);
  - a saturating-increment function used by all counters.
- One natural sub-module: sat_counter (COUNT_W wide; clear, inc, saturate), instantiated NUM_CLASSES times via generate.
- Argmax scan logic stays in the top.

Test Plan:
- Basic window:
  - Stimulus: L=5; spike_i[3]=1 every cycle, spike_i[7]=1 on 2 cycles, others 0.
  - Response: valid after 15 cycles; class_o=3, max_count_o=5, tie_o=0; dbg_sel_i=7 gives 2.
- Tie:
  - Stimulus: L=4; spike_i[2] and spike_i[6] high all 4 cycles.
  - Response: class_o=2, max_count_o=4, tie_o=1.
- Saturation:
  - Stimulus: COUNT_W=4, L=40, spike_i[9]=1 throughout.
  - Response: max_count_o=15, class_o=9, no wrap.
- Zero window:
  - Stimulus: L=0.
  - Response: valid after 10 cycles; class_o=0, max_count_o=0, tie_o=1.
- Handshake / back-to-back:
  - Stimulus: hold result_ready_i=0 for 7 cycles in DONE.
  - Response: outputs stable throughout.
  - Stimulus: then ready=1 with start_i=1 and L=3.
  - Response: busy_o=1 next cycle, new valid 13 cycles later; start_i pulsed during INTEGRATE has no effect.
- Reset mid-window:
  - Stimulus: assert rst_i on cycle 3 of an L=8 window.
  - Response: next cycle state IDLE, busy_o=0, result_valid_o=0, all dbg counts 0.
